// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED sequencer: mode encodings, mode-advance
// function and slide-switch field positions.
// Optional feature macro used elsewhere in the block: LED_SEQ_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
package led_seq_pkg;

  localparam logic [1:0] MODE_SHIFT  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_FLASH  = 2'd2;

  // Switch fields: [0] run, [NB_SPEED:1] speed, [NB_SPEED+1] direction
  localparam int SW_RUN     = 0;
  localparam int SW_SPD_LSB = 1;

  function automatic int sw_dir_idx(input int nb_speed);
    return nb_speed + 1;
  endfunction

  // Encoding 3 never gets loaded; it behaves like SHIFT, so advances to BOUNCE
  // would also be reasonable, but returning SHIFT gets it back on the cycle.
  function automatic logic [1:0] mode_next(input logic [1:0] m);
    case (m)
      MODE_SHIFT:  return MODE_BOUNCE;
      MODE_BOUNCE: return MODE_FLASH;
      default:     return MODE_SHIFT;
    endcase
  endfunction

endpackage

// File: rtl/led_seq_engine_if.sv
// ---------------------------------------------------------------------------
// led_seq_engine_if
// Board-facing switch/button inputs and LED/status outputs of the sequencer.
//   i_sw        : [0] run, [NB_SPEED:1] speed, [NB_SPEED+1] direction
//   i_btn       : [0] mode advance, [c+1] select colour c
//   o_led_color : channel c at [c*N_LEDS +: N_LEDS]
//   o_mode      : current mode
//   o_color_sel : one-hot active colour
//   o_tick      : one-cycle pulse per pattern step
// master = stimulus side, slave = sequencer.
// ---------------------------------------------------------------------------
interface led_seq_engine_if #(
  parameter int N_LEDS   = 4,
  parameter int N_COLORS = 3,
  parameter int NB_SPEED = 2
);
  logic [NB_SPEED+1:0]         i_sw;
  logic [N_COLORS:0]           i_btn;
  logic [N_COLORS*N_LEDS-1:0]  o_led_color;
  logic [1:0]                  o_mode;
  logic [N_COLORS-1:0]         o_color_sel;
  logic                        o_tick;

  modport master (
    output i_sw, i_btn,
    input  o_led_color, o_mode, o_color_sel, o_tick
  );

  modport slave (
    input  i_sw, i_btn,
    output o_led_color, o_mode, o_color_sel, o_tick
  );
endinterface

// File: rtl/btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// One push-button: 2-flop synchroniser, optional debounce, rising-edge pulse.
//   clock  : system clock
//   ck_rst : async active-low reset
//   btn_i  : raw asynchronous button level
//   edge_o : one-cycle pulse on a rising (debounced) level
// LED_SEQ_DEBOUNCE_EN: when defined, the level must be stable for DB_CYCLES
// consecutive samples before the edge detector sees it.
// ---------------------------------------------------------------------------
module btn_edge #(
  parameter int DB_CYCLES = 65536
) (
  input  logic clock,
  input  logic ck_rst,
  input  logic btn_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, prev_q, level;

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [CW-1:0] db_cnt_q;
  logic          db_q;

  // Counter tracks how long sync2 has disagreed with the accepted level;
  // any agreeing sample restarts the count.
  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (sync2_q == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == CW'(DB_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_q     <= sync2_q;
    end else begin
      db_cnt_q <= db_cnt_q + CW'(1);
    end
  end

  assign level = db_q;
`else
  // Parameter kept so both builds share one instantiation.
  logic unused_db;
  assign unused_db = (DB_CYCLES > 0);
  assign level     = sync2_q;
`endif

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) prev_q <= 1'b0;
    else         prev_q <= level;
  end

  assign edge_o = level & ~prev_q;

endmodule

// File: rtl/led_seq_engine.sv
// ---------------------------------------------------------------------------
// led_seq_engine
// LED pattern sequencer: rotate, bounce or flash one pattern across the
// selected colour channel at a switch-selected prescaled rate.
//   clock  : system clock (rising edge)
//   ck_rst : async active-low reset
//   bus    : led_seq_engine_if.slave (switches, buttons, LEDs, status)
// Build option: LED_SEQ_DEBOUNCE_EN adds button debouncing in btn_edge.
// ---------------------------------------------------------------------------
module led_seq_engine
  import led_seq_pkg::*;
#(
  parameter int N_LEDS     = 4,
  parameter int N_COLORS   = 3,
  parameter int NB_COUNT   = 32,
  parameter int NB_SPEED   = 2,
  parameter int SPEED_EXP0 = 22,
  parameter int DB_CYCLES  = 65536
) (
  input logic           clock,
  input logic           ck_rst,
  led_seq_engine_if.slave bus
);

  localparam int NB_BTN = N_COLORS + 1;
  localparam int SW_DIR = sw_dir_idx(NB_SPEED);

  localparam logic [NB_COUNT-1:0] CNT_ONE = NB_COUNT'(1);
  localparam logic [N_LEDS-1:0]   PAT_ONE = N_LEDS'(1);
  localparam logic [N_COLORS-1:0] SEL_ONE = N_COLORS'(1);

  logic [NB_BTN-1:0]   btn_ev;
  logic [NB_COUNT-1:0] cnt_q, limit;
  logic [N_LEDS-1:0]   pat_q, pat_step;
  logic [1:0]          mode_q, mode_nxt;
  logic                bdir_q, bdir_step;  // 0 = moving toward MSB
  logic                tick_q;
  logic [N_COLORS-1:0] sel_q, sel_d;
  logic                run, wrap, mode_ev;

  // ---- button front-ends ----
  genvar b;
  generate
    for (b = 0; b < NB_BTN; b++) begin : g_btn
      btn_edge #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clock  (clock),
        .ck_rst (ck_rst),
        .btn_i  (bus.i_btn[b]),
        .edge_o (btn_ev[b])
      );
    end
  endgenerate

  // ---- prescaler ----
  // A shift of exactly NB_COUNT yields 0, and 0 - 1 is all-ones: still correct.
  always_comb
    limit = (CNT_ONE << (SPEED_EXP0 + int'(bus.i_sw[SW_SPD_LSB +: NB_SPEED]))) - CNT_ONE;

  assign run     = bus.i_sw[SW_RUN];
  // >= rather than == so a speed decrease mid-count wraps immediately.
  assign wrap    = run & (cnt_q >= limit);
  assign mode_ev = btn_ev[0];
  assign mode_nxt = mode_next(mode_q);

  // ---- pattern step ----
  always_comb begin
    pat_step  = pat_q;
    bdir_step = bdir_q;
    case (mode_q)
      MODE_BOUNCE: begin
        if (!bdir_q) begin
          if (pat_q[N_LEDS-1]) begin
            pat_step  = pat_q >> 1;
            bdir_step = 1'b1;
          end else begin
            pat_step  = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            pat_step  = pat_q << 1;
            bdir_step = 1'b0;
          end else begin
            pat_step  = pat_q >> 1;
          end
        end
      end
      MODE_FLASH: pat_step = ~pat_q;
      default: begin
        if (!bus.i_sw[SW_DIR]) pat_step = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
        else                   pat_step = {pat_q[0], pat_q[N_LEDS-1:1]};
      end
    endcase
  end

  // Mode edge takes priority over a coincident step; tick still reports it.
  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      cnt_q  <= '0;
      pat_q  <= PAT_ONE;
      mode_q <= MODE_SHIFT;
      bdir_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (mode_ev) begin
        mode_q <= mode_nxt;
        pat_q  <= (mode_nxt == MODE_FLASH) ? '0 : PAT_ONE;
        cnt_q  <= '0;
        bdir_q <= 1'b0;
      end else if (wrap) begin
        cnt_q  <= '0;
        pat_q  <= pat_step;
        bdir_q <= bdir_step;
      end else if (run) begin
        cnt_q  <= cnt_q + CNT_ONE;
      end
    end
  end

  // ---- colour select: lowest-indexed edge wins ----
  always_comb begin
    sel_d = sel_q;
    for (int c = N_COLORS - 1; c >= 0; c--)
      if (btn_ev[c+1]) sel_d = SEL_ONE << c;
  end

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) sel_q <= SEL_ONE;
    else         sel_q <= sel_d;
  end

  // ---- outputs ----
  genvar c;
  generate
    for (c = 0; c < N_COLORS; c++) begin : g_col
      assign bus.o_led_color[c*N_LEDS +: N_LEDS] = sel_q[c] ? pat_q : '0;
    end
  endgenerate

  assign bus.o_mode      = mode_q;
  assign bus.o_color_sel = sel_q;
  assign bus.o_tick      = tick_q;

endmodule

// File: doc/led_seq_engine.md
# led_seq_engine

Parametrised LED sequencer for the board demo top level. It drives N_LEDS LEDs on each of N_COLORS colour channels with one pattern: rotate, bounce (ping-pong) or flash. Speed and direction come from slide switches; mode and colour come from push-buttons. Buttons pass through synchronisers and edge detectors, with optional debouncing.

## Interface
- N_LEDS, 4, LEDs per colour channel (≥2)
- N_COLORS, 3, colour channels; NB_BTN = N_COLORS+1
- NB_COUNT, 32, prescaler counter width
- NB_SPEED, 2, speed-select width; NB_SW = NB_SPEED+2
- SPEED_EXP0, 22, exponent for slowest-select limit; SPEED_EXP0+2^NB_SPEED-1 ≤ NB_COUNT
- DB_CYCLES, 2^16, debounce stability count (used only with debounce compiled in)
- clock  in  1  system clock, all logic on rising edge
- ck_rst  in  1  reset, asynchronous, active-low
- i_sw  in  NB_SW  [0] run enable; [NB_SPEED:1] speed select s; [NB_SW-1] direction, 0 = toward MSB
- i_btn  in  NB_BTN  [0] mode advance; [c+1] select colour c
- o_led_color  out  N_COLORS*N_LEDS  channel c at [c*N_LEDS +: N_LEDS]
- o_mode  out  2  current mode encoding
- o_color_sel  out  N_COLORS  one-hot active colour
- o_tick  out  1  one-cycle pulse per pattern step

## Operation
- Speed limit: limit = 2^(SPEED_EXP0+s) − 1, zero-extended to NB_COUNT.
- Prescaler, while i_sw[0]=1:
  - counter ≥ limit: counter←0, o_tick=1, pattern steps.
  - otherwise: counter+1.
  - The ≥ comparison handles a speed decrease while counting.
- i_sw[0]=0: counter and pattern hold; o_tick=0.
- Modes: SHIFT=0, BOUNCE=1, FLASH=2. Encoding 3 is unreachable and is treated as SHIFT.
- SHIFT step: rotate by one. dir 0: {p[N-2:0],p[N-1]}. dir 1: {p[0],p[N-1:1]}.
- BOUNCE step: one-hot moves per internal bdir.
  - At bit N_LEDS-1 moving up: reverse and move to N_LEDS-2.
  - At bit 0 moving down: reverse and move to 1.
  - i_sw[NB_SW-1] is ignored.
- FLASH step: pattern ← ~pattern. Reload value is all-zero.
- Mode button edge: mode advances SHIFT→BOUNCE→FLASH→SHIFT.
  - Pattern reloads: one-hot bit 0, or 0 for FLASH.
  - Counter←0; bdir←up.
  - Applies even when disabled.
- Colour button edges: o_color_sel←one-hot of the lowest-indexed edge this cycle; otherwise hold.
- Output: o_led_color channel c = pattern if o_color_sel[c], else 0.
- Simultaneous events:
  - Mode edge with tick: mode edge wins (reload, no step, o_tick still 1).
  - Mode edge with colour edge: both apply.
- Reset (ck_rst=0, any time, including mid-step):
  - counter=0, pattern=1, mode=SHIFT, bdir=up, o_color_sel=1, o_tick=0, edge-detector history=0.
  - Therefore o_led_color = channel 0 showing 0..01, all other channels 0.

## Timing
- Button path: 2-flop synchroniser, then a prev register.
  - Edge pulse = sync2 & ~prev.
  - A button high before edge k changes state after edge k+2 (no debounce).
- o_tick is registered; it is high in the cycle following the counter-wrap edge, the same edge on which the pattern changes.
- o_led_color, o_mode and o_color_sel are combinational from registers; no added latency.
- Step period = limit+1 cycles. The first step after enable or reload comes limit+1 cycles later.

## Configuration
- LED_SEQ_DEBOUNCE_EN defined:
  - Each synchronised button feeds a counter; the debounced level changes only after DB_CYCLES consecutive equal samples.
  - Edge detection uses the debounced level; latency is DB_CYCLES+3 edges.
- Undefined: no debounce logic; the edge detector uses sync2 directly. DB_CYCLES is unused.

## Structure
- Package led_seq_pkg: mode encodings (MODE_SHIFT/BOUNCE/FLASH), mode-next function, switch field indices.
- Sub-module btn_edge: one button per instance, containing the synchroniser, optional debounce and the rising-edge pulse. It is instantiated NB_BTN times via generate.

## Test plan
Bench parameters: NB_COUNT=8, SPEED_EXP0=2, NB_SPEED=2, N_LEDS=4, N_COLORS=3, debounce off.
- Reset release, sw=0001 (s=0, dir 0) -> steps every 4 cycles: red 0001→0010→0100→1000→0001; green/blue 0.
- sw dir bit=1, s=3 -> steps every 32 cycles, 0001→1000→0100; raise s to 3 from 0 mid-count -> no counter overflow, next step at limit.
- Mode btn pulse once -> o_mode=1, pattern 0001 after edge k+2; steps 0010,0100,1000,0100,0010,0001,0010.
- Mode btn twice more -> FLASH 0000→1111→0000 per step, then SHIFT reload 0001.
- btn[2] and btn[3] rise same cycle -> o_color_sel=010, green shows pattern, red/blue 0; sw[0]=0 -> pattern frozen, o_tick=0.
- Mode edge coincident with tick; ck_rst low mid-FLASH -> reload wins; reset gives mode 0, red 0001 immediately.
